bcd_countdown: RTL and testbench
================================

// Module: bcd_countdown
// PURPOSE
//  Multi-digit BCD down-counter/timer: presets a decimal value, counts down one
//  unit per prescaled tick, pulses Done on reaching zero. Timer counterpart to the
//  decade up-counter: feeds the same 7-segment decoders, one digit per display.
// PARAMETERS
//  DIGITS    4  number of BCD digits (Q width = 4*DIGITS)
//  TICK_DIV  1  Clk cycles per decrement (>=1; 1 = decrement every Clk)
// PORTS
//  Clk      in   1         system clock, rising edge
//  Rn       in   1         reset, asynchronous, active-low
//  Load     in   1         load preset D into Q
//  D        in   4*DIGITS  preset, packed BCD, digit 0 = D[3:0]
//  Start    in   1         start/resume countdown
//  Pause    in   1         freeze countdown
//  Q        out  4*DIGITS  current count, packed BCD
//  Running  out  1         1 while state==RUN
//  Done     out  1         one-cycle pulse on expiry
// BEHAVIOUR
//  Reset (Rn=0, async): Q=0, state IDLE, prescaler=0, Running=0, Done=0.
//  States: IDLE, RUN, HOLD, EXPIRED (2-bit, registered).
//  Priority per edge: Load > Pause > Start > tick.
//  Load (any state): Q<=D, digits >9 saturate to 9; state->IDLE; prescaler=0;
//    Done=0; an in-flight tick that cycle is discarded.
//  IDLE: Start & Q!=0 -> RUN; Start & Q==0 -> EXPIRED, Done=1 next cycle.
//  RUN: prescaler counts 0..TICK_DIV-1, wraps; tick = (prescaler==TICK_DIV-1).
//    On tick Q decrements by 1 in BCD. If Q was 0..01, Q becomes 0,
//    state->EXPIRED, Done=1 on that same edge (visible with Q==0).
//    Pause -> HOLD, prescaler value held (no tick lost or added). Start ignored.
//  HOLD: Q, prescaler frozen; Start (Pause=0) -> RUN; Pause&Start -> stay HOLD.
//  EXPIRED: Q=0 held; Start/Pause ignored; exit only via Load or reset.
//  Done: high exactly one cycle per expiry, cleared next edge.
//  BCD decrement: digit i borrow-in Bi; B0=tick; if Bi: Q_i==0 -> 9 and
//    B(i+1)=1, else Q_i-1 and B(i+1)=0. No wrap below 0 (EXPIRED blocks it).
//  Latency: Q/Done/Running registered; change on edge after qualifying input.
//  Reset mid-operation: immediate return to reset values, no Done.
// STRUCTURE
//  bcd_defs.vh: state encodings ST_IDLE/RUN/HOLD/EXPIRED, BCD_MAX=4'd9.
//  Sub-module bcd_down_digit (Clk, Rn, Ld, Din[3:0], En, Bin -> Q[3:0], Bout):
//    one digit register, Bout = Bin & (Q==0) combinational; generate DIGITS
//    instances chained Bout->Bin. Top holds FSM, prescaler, Done, zero detect.
// TESTING
//  1 DIGITS=4,TICK_DIV=1: Load D=0102, Start -> Q 0101,0100,0099,...;
//    Done single pulse on edge 102 after Start, Q=0000, Running=0 after.
//  2 Load 1000, Start -> after one tick Q=0999 (full borrow chain).
//  3 TICK_DIV=4: Load 0005, Start, Pause after 6 cycles (Q=0004, presc=1),
//    hold 10 cycles -> Q unchanged; Start -> next decrement 3 cycles later.
//  4 Load D=F0A3 -> Q=9093; Load 0000 then Start -> EXPIRED, one Done pulse.
//  5 Load asserted on a tick edge in RUN -> Q=D, IDLE, no decrement, no Done.
//  6 Rn low mid-RUN, async between edges -> Q=0000, Running=0, Done=0 at once.

Source files
------------

// File: rtl/bcd_countdown_pkg.sv
// Shared types for the BCD countdown timer.
// State encodings, digit limit and preset saturation helper.
package bcd_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_sat(
    input logic [3:0] d
  );
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_digit.sv
// One BCD digit of the down-counter.
// Borrow ripples out combinationally when the digit sits at zero.
module bcd_countdown_digit
  import bcd_countdown_pkg::*;
(
  input  logic       Clk,
  input  logic       Rn,
  input  logic       Ld,
  input  logic [3:0] Din,
  input  logic       En,
  input  logic       Bin,
  output logic [3:0] Q,
  output logic       Bout
);

  assign Bout = Bin & (Q == 4'd0);

  // digit register: load saturates, borrow-in decrements with 0->9 wrap
  always_ff @(posedge Clk or negedge Rn) begin
    if (!Rn) begin
      Q <= 4'd0;
    end else if (Ld) begin
      Q <= bcd_sat(Din);
    end else if (En && Bin) begin
      Q <= (Q == 4'd0) ? BCD_MAX : Q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_countdown.sv
// Multi-digit BCD countdown timer.
// Prescaled decrement, run/hold/expire control, one-cycle Done.
module bcd_countdown
  import bcd_countdown_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                Clk,
  input  logic                Rn,
  input  logic                Load,
  input  logic [4*DIGITS-1:0] D,
  input  logic                Start,
  input  logic                Pause,
  output logic [4*DIGITS-1:0] Q,
  output logic                Running,
  output logic                Done
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX =
    PW'(TICK_DIV - 1);
  localparam logic [4*DIGITS-1:0] ONE =
    {{(4*DIGITS-1){1'b0}}, 1'b1};

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic          done_nxt;
  logic          dec;
  logic          q_zero;
  logic          q_one;
  logic [DIGITS:0] borrow;
  logic          borrow_unused;

  assign borrow[0]     = dec;
  assign borrow_unused = borrow[DIGITS];
  assign q_zero        = (Q == '0);
  assign q_one         = (Q == ONE);
  assign Running       = (state == ST_RUN);

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_countdown_digit u_digit (
      .Clk  (Clk),
      .Rn   (Rn),
      .Ld   (Load),
      .Din  (D[4*i +: 4]),
      .En   (dec),
      .Bin  (borrow[i]),
      .Q    (Q[4*i +: 4]),
      .Bout (borrow[i+1])
    );
  end

  // next state, prescaler, decrement strobe and expiry pulse
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    done_nxt  = 1'b0;
    dec       = 1'b0;
    if (Load) begin
      state_nxt = ST_IDLE;
      presc_nxt = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (Start && !Pause) begin
            if (q_zero) begin
              state_nxt = ST_EXPIRED;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (Pause) begin
            state_nxt = ST_HOLD;
          end else if (presc == PMAX) begin
            presc_nxt = '0;
            dec       = 1'b1;
            if (q_one) begin
              state_nxt = ST_EXPIRED;
              done_nxt  = 1'b1;
            end
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end
        ST_HOLD: begin
          if (Start && !Pause) begin
            state_nxt = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          state_nxt = ST_EXPIRED;
        end
      endcase
    end
  end

  // control registers
  always_ff @(posedge Clk or negedge Rn) begin
    if (!Rn) begin
      state <= ST_IDLE;
      presc <= '0;
      Done  <= 1'b0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      Done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_countdown.sv
// Testbench for bcd_countdown.
// Table vectors plus hand-written multi-cycle sequences.
module tb_bcd_countdown;

  logic        clk = 1'b0;
  logic        rn;
  logic        load;
  logic [15:0] d;
  logic        start;
  logic        pause;
  logic [15:0] q1;
  logic        run1;
  logic        done1;
  logic [15:0] q4;
  logic        run4;
  logic        done4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_countdown #(.DIGITS(4), .TICK_DIV(1)) u_d1 (
    .Clk(clk), .Rn(rn), .Load(load), .D(d),
    .Start(start), .Pause(pause),
    .Q(q1), .Running(run1), .Done(done1)
  );

  bcd_countdown #(.DIGITS(4), .TICK_DIV(4)) u_d4 (
    .Clk(clk), .Rn(rn), .Load(load), .D(d),
    .Start(start), .Pause(pause),
    .Q(q4), .Running(run4), .Done(done4)
  );

  typedef struct {
    logic        ld;
    logic [15:0] dv;
    logic        st;
    logic        pa;
    logic [15:0] eq;
    logic        er;
    logic        ed;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic l, input logic [15:0] dv,
                      input logic s, input logic p);
    load  = l;
    d     = dv;
    start = s;
    pause = p;
    @(posedge clk);
    #1;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  initial begin
    int pulses;
    tbl[0]  = '{1'b1, 16'hF0A3, 1'b0, 1'b0, 16'h9093, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 16'h1000, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0999, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0999, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0999, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0999, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0999, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0998, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0997, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 16'h0002, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 16'h9A5B, 1'b0, 1'b0, 16'h9959, 1'b0, 1'b0};

    rn    = 1'b0;
    load  = 1'b0;
    d     = 16'h0;
    start = 1'b0;
    pause = 1'b0;
    #12;
    chk("rst_q",    q1,    16'h0);
    chk("rst_run",  16'(run1),  16'h0);
    chk("rst_done", 16'(done1), 16'h0);
    chk("rst_q4",   q4,    16'h0);
    @(negedge clk);
    rn = 1'b1;
    @(posedge clk);
    #1;

    // table vectors on the TICK_DIV=1 instance
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].ld, tbl[i].dv, tbl[i].st, tbl[i].pa);
      chk($sformatf("v%0d_q", i), q1, tbl[i].eq);
      chk($sformatf("v%0d_run", i), 16'(run1), 16'(tbl[i].er));
      chk($sformatf("v%0d_done", i), 16'(done1), 16'(tbl[i].ed));
    end

    // full countdown from 102
    step(1'b1, 16'h0102, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("cd_start_q", q1, 16'h0102);
    pulses = 0;
    for (int k = 1; k <= 102; k++) begin
      step(1'b0, 16'h0, 1'b0, 1'b0);
      if (done1) pulses++;
      chk($sformatf("cd%0d_q", k), q1, to_bcd(102 - k));
      chk($sformatf("cd%0d_done", k), 16'(done1),
          16'(k == 102));
      chk($sformatf("cd%0d_run", k), 16'(run1),
          16'(k < 102));
    end
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("cd_after_done", 16'(done1), 16'h0);
    chk("cd_after_q", q1, 16'h0000);
    chk("cd_pulses", 16'(pulses), 16'd1);

    // prescaled run with pause/resume on TICK_DIV=4
    step(1'b1, 16'h0005, 1'b0, 1'b0);
    chk("p_load", q4, 16'h0005);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("p_before_pause", q4, 16'h0004);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("p_hold_run", 16'(run4), 16'h0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 16'h0, 1'b0, 1'b0);
      chk($sformatf("p_hold%0d", k), q4, 16'h0004);
    end
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("p_resume_run", 16'(run4), 16'h1);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("p_r1", q4, 16'h0004);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("p_r2", q4, 16'h0004);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("p_r3", q4, 16'h0003);

    // load on a tick edge of the prescaled instance
    for (int k = 0; k < 3; k++) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("lt4_pre", q4, 16'h0003);
    step(1'b1, 16'h0007, 1'b0, 1'b0);
    chk("lt4_q", q4, 16'h0007);
    chk("lt4_run", 16'(run4), 16'h0);
    chk("lt4_done", 16'(done4), 16'h0);

    // load on a tick edge of the TICK_DIV=1 instance
    step(1'b1, 16'h0500, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("lt1_pre", q1, 16'h0499);
    step(1'b1, 16'h0300, 1'b0, 1'b0);
    chk("lt1_q", q1, 16'h0300);
    chk("lt1_run", 16'(run1), 16'h0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("lt1_idle", q1, 16'h0300);

    // asynchronous reset between edges while running
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("ar_pre", q1, 16'h0299);
    #2;
    rn = 1'b0;
    #1;
    chk("ar_q", q1, 16'h0);
    chk("ar_run", 16'(run1), 16'h0);
    chk("ar_done", 16'(done1), 16'h0);
    chk("ar_q4", q4, 16'h0);
    @(negedge clk);
    rn = 1'b1;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("ar_hold", q1, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
